// File: rtl/binary_down_counter_timer.sv
// Loadable WIDTH-bit binary down counter with one-cycle terminal-count pulse,
// one-shot or auto-reload operation, and a registered busy flag.
module binary_down_counter_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;
    logic             tc_evt;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_evt   = 1'b0;

        if (load) begin
            count_d  = load_val;
            reload_d = load_val;
            if (load_val != '0) begin
                state_d = RUN;
            end else begin
                state_d = DONE;
                tc_evt  = 1'b1;
            end
        end else if (state_q == RUN && en) begin
            if (count_q > WIDTH'(1)) begin
                count_d = count_q - WIDTH'(1);
            end else if (count_q == WIDTH'(1)) begin
                count_d = '0;
                tc_evt  = 1'b1;
                if (!auto_reload) begin
                    state_d = DONE;
                end
            end else begin
                // Zero is only reachable in RUN via auto-reload; restart the period.
                count_d = reload_q;
            end
        end

        // A back-to-back event (e.g. a zero load right after expiry) must not stretch the pulse.
        tc_d = tc_evt & ~tc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign busy  = (state_q == RUN);

endmodule

// File: tb/tb_binary_down_counter_timer.sv
// Self-checking bench for binary_down_counter_timer: directed scenarios plus
// randomized traffic compared against a behavioural timer model.
module tb_binary_down_counter_timer;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst_n;
    logic         load;
    logic [W-1:0] load_val;
    logic         en;
    logic         auto_reload;
    logic [W-1:0] count;
    logic         tc;
    logic         busy;

    int n_checks;
    int n_pass;

    // Behavioural model: remaining count, saved period, running flag, pulse.
    logic [W-1:0] m_count;
    logic [W-1:0] m_reload;
    bit           m_run;
    bit           m_tc;

    binary_down_counter_timer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .load_val   (load_val),
        .en         (en),
        .auto_reload(auto_reload),
        .count      (count),
        .tc         (tc),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_count  = '0;
        m_reload = '0;
        m_run    = 1'b0;
        m_tc     = 1'b0;
    endtask

    // Advance the model by one edge using the inputs that are about to be sampled.
    task automatic model_edge();
        bit expired;
        expired = 1'b0;
        if (load) begin
            m_count  = load_val;
            m_reload = load_val;
            m_run    = (load_val != 0);
            expired  = (load_val == 0);
        end else if (m_run && en) begin
            if (m_count == 0) begin
                m_count = m_reload;
            end else begin
                m_count = m_count - 1;
                if (m_count == 0) begin
                    expired = 1'b1;
                    m_run   = auto_reload;
                end
            end
        end
        m_tc = expired && !m_tc;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; auto_reload = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        n_checks++;
        if ({count, tc, busy} !== {4'd0, 1'b0, 1'b0})
            $display("FAIL reset_state: count=%0d tc=%b busy=%b, want 0/0/0", count, tc, busy);
        else n_pass++;
        rst_n = 1'b1;
        // T1: asynchronous reset mid-count
        load = 1'b1; load_val = 4'd7; en = 1'b1;
        tick();
        load = 1'b0;
        tick(); tick(); tick();
        n_checks++;
        if (count !== 4'd4) $display("FAIL t1_precount: count=%0d, want 4", count);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({count, tc, busy} !== {4'd0, 1'b0, 1'b0})
            $display("FAIL t1_async_reset: count=%0d tc=%b busy=%b, want 0/0/0", count, tc, busy);
        else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1; en = 1'b0;
    endtask

    task automatic test_one_shot();
        logic [W-1:0] exp;
        load = 1'b1; load_val = 4'd3; auto_reload = 1'b0; en = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            exp = W'(3 - i);
            n_checks++;
            if (count !== exp || tc !== (i == 3) || busy !== (i != 3))
                $display("FAIL t2_seq[%0d]: count=%0d tc=%b busy=%b, want %0d/%b/%b",
                         i, count, tc, busy, exp, (i == 3), (i != 3));
            else n_pass++;
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (count !== 4'd0 || tc !== 1'b0 || busy !== 1'b0)
                $display("FAIL t2_hold[%0d]: count=%0d tc=%b busy=%b, want 0/0/0", i, count, tc, busy);
            else n_pass++;
        end
    endtask

    task automatic test_auto_reload();
        logic [W-1:0] exp;
        int pulses;
        pulses = 0;
        load = 1'b1; load_val = 4'd15; auto_reload = 1'b1; en = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 1; k <= 48; k++) begin
            tick();
            exp = W'(15 - k);
            if (tc === 1'b1) pulses++;
            n_checks++;
            if (count !== exp || busy !== 1'b1 || tc !== (exp == 0))
                $display("FAIL t3_wrap[%0d]: count=%0d tc=%b busy=%b, want %0d/%b/1",
                         k, count, tc, busy, exp, (exp == 0));
            else n_pass++;
        end
        n_checks++;
        if (pulses !== 3) $display("FAIL t3_pulses: got %0d tc pulses, want 3", pulses);
        else n_pass++;
    endtask

    task automatic test_enable_hold();
        load = 1'b1; load_val = 4'd8; auto_reload = 1'b0; en = 1'b1;
        tick();
        load = 1'b0;
        tick(); tick(); tick();
        n_checks++;
        if (count !== 4'd5) $display("FAIL t4_reach5: count=%0d, want 5", count);
        else n_pass++;
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (count !== 4'd5 || tc !== 1'b0 || busy !== 1'b1)
                $display("FAIL t4_hold[%0d]: count=%0d tc=%b busy=%b, want 5/0/1", i, count, tc, busy);
            else n_pass++;
        end
        en = 1'b1;
        tick();
        tick();
        n_checks++;
        if (count !== 4'd3) $display("FAIL t4_resume: count=%0d, want 3", count);
        else n_pass++;
    endtask

    task automatic test_reload_midrun();
        load = 1'b1; load_val = 4'd6; auto_reload = 1'b0; en = 1'b1;
        tick();
        load = 1'b0;
        repeat (4) tick();
        n_checks++;
        if (count !== 4'd2) $display("FAIL t5_reach2: count=%0d, want 2", count);
        else n_pass++;
        load = 1'b1; load_val = 4'd9;
        tick();
        load = 1'b0;
        n_checks++;
        if (count !== 4'd9 || tc !== 1'b0 || busy !== 1'b1)
            $display("FAIL t5_reload: count=%0d tc=%b busy=%b, want 9/0/1", count, tc, busy);
        else n_pass++;
    endtask

    task automatic test_load_zero();
        load = 1'b1; load_val = 4'd0; en = 1'b0;
        tick();
        load = 1'b0; en = 1'b1;
        n_checks++;
        if (count !== 4'd0 || tc !== 1'b1 || busy !== 1'b0)
            $display("FAIL t6_load0: count=%0d tc=%b busy=%b, want 0/1/0", count, tc, busy);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (count !== 4'd0 || tc !== 1'b0 || busy !== 1'b0)
                $display("FAIL t6_after[%0d]: count=%0d tc=%b busy=%b, want 0/0/0", i, count, tc, busy);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic prev_tc;
        prev_tc = tc;
        for (int i = 0; i < 600; i++) begin
            load        = ($urandom_range(0, 9) == 0);
            load_val    = ($urandom_range(0, 5) == 0) ? 4'd0 : W'($urandom_range(1, 15));
            en          = ($urandom_range(0, 3) != 0);
            auto_reload = ($urandom_range(0, 2) != 0);
            tick();
            n_checks++;
            if (count !== m_count || tc !== m_tc || busy !== m_run)
                $display("FAIL rand_cycle[%0d]: count=%0d tc=%b busy=%b, want %0d/%b/%b",
                         i, count, tc, busy, m_count, m_tc, m_run);
            else n_pass++;
            n_checks++;
            if (prev_tc === 1'b1 && tc === 1'b1)
                $display("FAIL rand_tc_width[%0d]: tc=1 on two consecutive cycles, want single pulse", i);
            else n_pass++;
            prev_tc = tc;
        end
        load = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_enable_hold();
        test_reload_midrun();
        test_load_zero();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
